// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - ID-stage forwarding select and load-use stall generation
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_dest,
  input  logic        id_writes_reg,
  input  logic        id_is_load,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic [31:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // Scoreboard slots describing the writers currently in EX, MEM and WB.
  logic       ex_valid,  mem_valid,  wb_valid;
  logic [4:0] ex_dest,   mem_dest,   wb_dest;
  logic       ex_load,   mem_load,   wb_load;

  logic ex_hit_rs, ex_hit_rt;

  // Register $0 is hardwired, so a writer of $0 never supplies a value.
  function automatic logic slot_match(input logic valid, input logic [4:0] dest,
                                      input logic [4:0] src);
    return valid && (dest == src) && (src != 5'd0);
  endfunction

  // Youngest matching slot wins; an unused operand always reads the register file.
  function automatic logic [1:0] pick_sel(input logic used, input logic [4:0] src,
                                          input logic exv, input logic [4:0] exd,
                                          input logic mev, input logic [4:0] med,
                                          input logic wbv, input logic [4:0] wbd,
                                          input logic idv);
    if (!used || !idv)                 return SEL_RF;
    else if (slot_match(exv, exd, src)) return SEL_EX;
    else if (slot_match(mev, med, src)) return SEL_MEM;
    else if (slot_match(wbv, wbd, src)) return SEL_WB;
    else                                return SEL_RF;
  endfunction

  // Operand selects for both ID source ports, each from its own source register.
  always_comb begin
    fwd_a = pick_sel(id_uses_rs, id_rs, ex_valid, ex_dest, mem_valid, mem_dest,
                     wb_valid, wb_dest, id_valid);
    fwd_b = pick_sel(id_uses_rt, id_rt, ex_valid, ex_dest, mem_valid, mem_dest,
                     wb_valid, wb_dest, id_valid);
  end

  // A load in EX cannot forward yet, so a dependent ID instruction waits one cycle.
  always_comb begin
    ex_hit_rs = id_uses_rs && slot_match(ex_valid, ex_dest, id_rs);
    ex_hit_rt = id_uses_rt && slot_match(ex_valid, ex_dest, id_rt);
    stall     = id_valid && ex_load && (ex_hit_rs || ex_hit_rt);
  end

  // Advance the scoreboard; a stall turns the EX entry into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      if (stall) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= id_valid & id_writes_reg;
        ex_dest  <= id_dest;
        ex_load  <= id_is_load;
      end
      mem_valid <= ex_valid;
      mem_dest  <= ex_dest;
      mem_load  <= ex_load;
      wb_valid  <= mem_valid;
      wb_dest   <= mem_dest;
      wb_load   <= mem_load;
    end
  end

  // Free-running count of stalled cycles; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst)        stall_count <= 32'd0;
    else if (stall) stall_count <= stall_count + 32'd1;
  end

  // WB load flag is tracked for completeness of the slot record but not consumed.
  logic unused_wb_load;
  assign unused_wb_load = wb_load;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed-vector bench for hazard_unit
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_dest;
  logic        id_writes_reg;
  logic        id_is_load;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        stall;
  logic [31:0] stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_writes_reg(id_writes_reg), .id_is_load(id_is_load),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] d,
                        input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = d; id_writes_reg = wr; id_is_load = ld;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_stall", stall, 0);
    check("reset_fwd_a", fwd_a, 0);
    check("reset_fwd_b", fwd_b, 0);
    check("reset_count", stall_count, 0);

    // add $3 in ID, then sub reading $3
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    check("add_fwd_a", fwd_a, 2'b00);
    step();
    set_id(1, 3, 4, 1, 1, 8, 1, 0);
    check("sub_fwd_a_ex", fwd_a, 2'b01);
    check("sub_fwd_b_rf", fwd_b, 2'b00);
    check("sub_stall", stall, 0);
    step();
    set_id(1, 3, 8, 1, 1, 0, 0, 0);
    check("fwd_a_mem", fwd_a, 2'b10);
    check("fwd_b_ex", fwd_b, 2'b01);
    step();
    check("fwd_a_wb", fwd_a, 2'b11);
    check("fwd_b_mem", fwd_b, 2'b10);

    // lw $5 then beq $5,$0
    set_id(1, 1, 0, 1, 0, 5, 1, 1);
    step();
    set_id(1, 5, 0, 1, 1, 0, 0, 0);
    check("lu_stall", stall, 1);
    check("lu_fwd_a_ex", fwd_a, 2'b01);
    check("lu_count0", stall_count, 0);
    step();
    check("lu_stall_done", stall, 0);
    check("lu_fwd_a_mem", fwd_a, 2'b10);
    check("lu_fwd_b", fwd_b, 2'b00);
    check("lu_count1", stall_count, 1);

    // three writers of $7
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    step(); step(); step();
    set_id(1, 7, 7, 1, 1, 0, 0, 0);
    check("r7_fwd_a_ex", fwd_a, 2'b01);
    check("r7_fwd_b_ex", fwd_b, 2'b01);
    step();
    check("r7_fwd_a_mem", fwd_a, 2'b10);
    check("r7_fwd_b_mem", fwd_b, 2'b10);

    // writers of $0 never match
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    step();
    set_id(1, 0, 0, 1, 1, 0, 1, 1);
    check("r0_fwd_a", fwd_a, 2'b00);
    check("r0_stall", stall, 0);
    step();
    set_id(1, 0, 0, 1, 1, 0, 0, 0);
    check("r0_load_fwd_a", fwd_a, 2'b00);
    check("r0_load_fwd_b", fwd_b, 2'b00);
    check("r0_load_stall", stall, 0);

    // invalid ID behind a load of $9
    set_id(1, 0, 0, 0, 0, 9, 1, 1);
    step();
    set_id(0, 9, 9, 1, 1, 9, 1, 1);
    check("inv_stall", stall, 0);
    check("inv_fwd_a", fwd_a, 2'b00);
    step();
    set_id(1, 9, 0, 1, 0, 0, 0, 0);
    check("inv_ex_empty_fwd", fwd_a, 2'b10);
    check("inv_ex_empty_stall", stall, 0);

    // stall via rt only, and not when rt unused
    set_id(1, 0, 0, 0, 0, 10, 1, 1);
    step();
    set_id(1, 10, 10, 0, 1, 0, 0, 0);
    check("rt_stall", stall, 1);
    check("rt_fwd_a", fwd_a, 2'b00);
    check("rt_fwd_b", fwd_b, 2'b01);
    set_id(1, 10, 10, 0, 0, 0, 0, 0);
    check("rt_unused_stall", stall, 0);

    // reset in the middle of a load-use stall
    set_id(1, 0, 0, 0, 0, 6, 1, 1);
    step();
    set_id(1, 6, 6, 1, 1, 0, 0, 0);
    check("rst_pre_stall", stall, 1);
    check("rst_pre_count", stall_count, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_count", stall_count, 0);
    check("rst_fwd_a", fwd_a, 2'b00);
    check("rst_fwd_b", fwd_b, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
